tinyqv_periph_bus: RTL and testbench

TINYQV_PERIPH_BUS -- requirements
Module: tinyqv_periph_bus

---
 rtl/tinyqv_periph_bus.sv | 191 +++++++++++++++++++
 tb/tb_tinyqv_periph_bus.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_periph_bus.sv
// Peripheral bus bridge: decodes one CPU access onto a per-channel strobe,
// waits for that channel's ready (bounded), and answers the CPU with one pulse.
module tinyqv_periph_bus #(
  parameter int unsigned NUM_PERIPH = 4,
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned SEL_LSB    = 6,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [1:0]                cpu_write_n,
  input  logic [1:0]                cpu_read_n,
  input  logic [31:0]               cpu_data_out,
  output logic                      cpu_data_ready,
  output logic [31:0]               cpu_data_in,
  output logic [ADDR_W-1:0]         p_addr,
  output logic [31:0]               p_data_out,
  output logic [2*NUM_PERIPH-1:0]   p_write_n,
  output logic [2*NUM_PERIPH-1:0]   p_read_n,
  input  logic [NUM_PERIPH-1:0]     p_ready,
  input  logic [32*NUM_PERIPH-1:0]  p_data_in,
  output logic                      bus_error,
  output logic [7:0]                err_count
);

  localparam int unsigned SEL_W  = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  localparam int unsigned STRB_W = 2 * NUM_PERIPH;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         wdata_d;
  logic [STRB_W-1:0]   pw_d, pr_d;
  logic [31:0]         rdata_d;
  logic                rdy_d;
  logic                err_d;
  logic [7:0]          errcnt_d;

  logic                req_c;
  logic                req_wr_c;
  logic [1:0]          req_size_c;
  logic [SEL_W-1:0]    req_idx_c;
  logic                req_mapped_c;
  logic [STRB_W-1:0]   req_strb_c;
  logic                sel_ready_c;
  logic [31:0]         sel_data_c;
  logic [7:0]          err_inc_c;

  // Request decode: write beats read when both strobes are active.
  always_comb begin
    req_wr_c     = (cpu_write_n != 2'b11);
    req_c        = req_wr_c || (cpu_read_n != 2'b11);
    req_size_c   = req_wr_c ? cpu_write_n : cpu_read_n;
    req_idx_c    = cpu_addr[SEL_LSB +: SEL_W];
    req_mapped_c = (32'(req_idx_c) < 32'(NUM_PERIPH));
    req_strb_c   = {STRB_W{1'b1}};
    for (int k = 0; k < int'(NUM_PERIPH); k++) begin
      if (req_idx_c == SEL_W'(k)) req_strb_c[2*k +: 2] = req_size_c;
    end
  end

  // Select ready and read data of the latched channel only.
  always_comb begin
    sel_ready_c = 1'b0;
    sel_data_c  = 32'd0;
    for (int k = 0; k < int'(NUM_PERIPH); k++) begin
      if (idx_q == SEL_W'(k)) begin
        sel_ready_c = p_ready[k];
        sel_data_c  = p_data_in[32*k +: 32];
      end
    end
  end

  // Saturating increment of the error counter.
  always_comb begin
    err_inc_c = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
  end

  // Next-state and next-output logic. Timeout fires on the TIMEOUT-th strobe
  // cycle without ready; a ready seen in that same cycle still completes.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    addr_d   = p_addr;
    wdata_d  = p_data_out;
    pw_d     = p_write_n;
    pr_d     = p_read_n;
    rdata_d  = cpu_data_in;
    rdy_d    = 1'b0;
    err_d    = 1'b0;
    errcnt_d = err_count;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          idx_d   = req_idx_c;
          wr_d    = req_wr_c;
          addr_d  = cpu_addr;
          wdata_d = cpu_data_out;
          cnt_d   = '0;
          if (req_mapped_c) begin
            state_d = ACTIVE;
            if (req_wr_c) pw_d = req_strb_c;
            else          pr_d = req_strb_c;
          end else begin
            state_d  = RESP;
            rdata_d  = 32'd0;
            rdy_d    = 1'b1;
            err_d    = 1'b1;
            errcnt_d = err_inc_c;
          end
        end
      end

      ACTIVE: begin
        if (sel_ready_c) begin
          state_d = RESP;
          pw_d    = {STRB_W{1'b1}};
          pr_d    = {STRB_W{1'b1}};
          rdata_d = wr_q ? 32'd0 : sel_data_c;
          rdy_d   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          pw_d     = {STRB_W{1'b1}};
          pr_d     = {STRB_W{1'b1}};
          rdata_d  = 32'd0;
          rdy_d    = 1'b1;
          err_d    = 1'b1;
          errcnt_d = err_inc_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        pw_d    = {STRB_W{1'b1}};
        pr_d    = {STRB_W{1'b1}};
      end
    endcase
  end

  // State and registered outputs; reset drops strobes immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      wr_q           <= 1'b0;
      cnt_q          <= '0;
      p_addr         <= '0;
      p_data_out     <= 32'd0;
      p_write_n      <= {STRB_W{1'b1}};
      p_read_n       <= {STRB_W{1'b1}};
      cpu_data_in    <= 32'd0;
      cpu_data_ready <= 1'b0;
      bus_error      <= 1'b0;
      err_count      <= 8'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wr_q           <= wr_d;
      cnt_q          <= cnt_d;
      p_addr         <= addr_d;
      p_data_out     <= wdata_d;
      p_write_n      <= pw_d;
      p_read_n       <= pr_d;
      cpu_data_in    <= rdata_d;
      cpu_data_ready <= rdy_d;
      bus_error      <= err_d;
      err_count      <= errcnt_d;
    end
  end

endmodule

// File: tb/tb_tinyqv_periph_bus.sv
// Directed bench for tinyqv_periph_bus with three channels, TIMEOUT=15.
module tb_tinyqv_periph_bus;

  localparam int unsigned NP = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [27:0] cpu_addr;
  logic [1:0]  cpu_write_n;
  logic [1:0]  cpu_read_n;
  logic [31:0] cpu_data_out;
  logic        cpu_data_ready;
  logic [31:0] cpu_data_in;
  logic [27:0] p_addr;
  logic [31:0] p_data_out;
  logic [2*NP-1:0]  p_write_n;
  logic [2*NP-1:0]  p_read_n;
  logic [NP-1:0]    p_ready;
  logic [32*NP-1:0] p_data_in;
  logic        bus_error;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  tinyqv_periph_bus #(
    .NUM_PERIPH(NP), .ADDR_W(28), .SEL_LSB(6), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cpu_addr(cpu_addr), .cpu_write_n(cpu_write_n), .cpu_read_n(cpu_read_n),
    .cpu_data_out(cpu_data_out), .cpu_data_ready(cpu_data_ready),
    .cpu_data_in(cpu_data_in), .p_addr(p_addr), .p_data_out(p_data_out),
    .p_write_n(p_write_n), .p_read_n(p_read_n), .p_ready(p_ready),
    .p_data_in(p_data_in), .bus_error(bus_error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cpu();
    cpu_write_n = 2'b11;
    cpu_read_n  = 2'b11;
  endtask

  task automatic test_reset();
    rstn = 1'b0; idle_cpu(); cpu_addr = '0; cpu_data_out = '0;
    p_ready = '0; p_data_in = '0;
    tick(); tick();
    checks++; if (p_write_n !== 6'h3F) begin errors++; $display("FAIL reset_pw: got %h exp 3f", p_write_n); end
    checks++; if (p_read_n !== 6'h3F) begin errors++; $display("FAIL reset_pr: got %h exp 3f", p_read_n); end
    checks++; if ({cpu_data_ready, bus_error, err_count} !== 10'd0) begin errors++; $display("FAIL reset_flags: got rdy=%b err=%b cnt=%0d exp 0", cpu_data_ready, bus_error, err_count); end
    checks++; if ({cpu_data_in, p_data_out, p_addr} !== 92'd0) begin errors++; $display("FAIL reset_data: got %h %h %h exp 0", cpu_data_in, p_data_out, p_addr); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_read_min();
    p_data_in[64 +: 32] = 32'hDEADBEEF;
    cpu_addr = 28'h0000080; cpu_read_n = 2'b10;
    tick();
    idle_cpu();
    checks++; if (p_read_n !== 6'b10_11_11) begin errors++; $display("FAIL rd_strobe: got %b exp 101111", p_read_n); end
    checks++; if (cpu_data_ready !== 1'b0) begin errors++; $display("FAIL rd_early_rdy: got %b exp 0", cpu_data_ready); end
    p_ready = 3'b100;
    tick();
    p_ready = '0;
    checks++; if (cpu_data_ready !== 1'b1 || cpu_data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_resp: got rdy=%b data=%h exp 1 deadbeef", cpu_data_ready, cpu_data_in); end
    checks++; if (bus_error !== 1'b0 || p_read_n !== 6'h3F) begin errors++; $display("FAIL rd_done: got err=%b pr=%b exp 0 111111", bus_error, p_read_n); end
    tick();
    checks++; if (cpu_data_ready !== 1'b0 || cpu_data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got rdy=%b data=%h exp 0 deadbeef", cpu_data_ready, cpu_data_in); end
  endtask

  task automatic test_write_byte();
    int strobe_cycles = 0;
    cpu_addr = 28'h0000040; cpu_write_n = 2'b00; cpu_data_out = 32'h0000005A;
    tick();
    idle_cpu(); cpu_data_out = 32'hFFFFFFFF;
    for (int i = 1; i <= 4; i++) begin
      if (p_write_n === 6'b11_00_11 && p_read_n === 6'h3F && cpu_data_ready === 1'b0) strobe_cycles++;
      if (i == 4) p_ready = 3'b010;
      tick();
    end
    p_ready = '0;
    checks++; if (strobe_cycles !== 4) begin errors++; $display("FAIL wr_strobe_cycles: got %0d exp 4", strobe_cycles); end
    checks++; if (p_data_out !== 32'h5A || p_addr !== 28'h40) begin errors++; $display("FAIL wr_payload: got %h %h exp 5a 40", p_data_out, p_addr); end
    checks++; if (cpu_data_ready !== 1'b1 || cpu_data_in !== 32'd0 || bus_error !== 1'b0) begin errors++; $display("FAIL wr_resp: got rdy=%b data=%h err=%b exp 1 0 0", cpu_data_ready, cpu_data_in, bus_error); end
    checks++; if (p_write_n !== 6'h3F) begin errors++; $display("FAIL wr_drop: got %b exp 111111", p_write_n); end
    tick();
    checks++; if (cpu_data_ready !== 1'b0) begin errors++; $display("FAIL wr_one_pulse: got %b exp 0", cpu_data_ready); end
  endtask

  task automatic test_both_strobes();
    cpu_addr = 28'h0000040; cpu_write_n = 2'b10; cpu_read_n = 2'b10; cpu_data_out = 32'h11223344;
    tick();
    idle_cpu();
    checks++; if (p_write_n !== 6'b11_10_11 || p_read_n !== 6'h3F) begin errors++; $display("FAIL both_prec: got pw=%b pr=%b exp 111011 111111", p_write_n, p_read_n); end
    p_ready = 3'b010;
    tick();
    p_ready = '0;
    checks++; if (cpu_data_ready !== 1'b1 || cpu_data_in !== 32'd0) begin errors++; $display("FAIL both_resp: got rdy=%b data=%h exp 1 0", cpu_data_ready, cpu_data_in); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] rdy_seen = '0;
    cpu_addr = 28'h0000080; cpu_read_n = 2'b00;
    p_ready = 3'b100; p_data_in[64 +: 32] = 32'hCAFEF00D;
    for (int i = 1; i <= 5; i++) begin
      tick();
      rdy_seen[i] = cpu_data_ready;
      if (i == 3) p_data_in[64 +: 32] = 32'h0BADF00D;
    end
    idle_cpu(); p_ready = '0;
    checks++; if (rdy_seen !== 6'b100100) begin errors++; $display("FAIL b2b_pattern: got %b exp 100100", rdy_seen); end
    checks++; if (cpu_data_in !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_second_data: got %h exp 0badf00d", cpu_data_in); end
    tick();
  endtask

  task automatic run_timeout(input logic [2:0] rdy, input int late_ready,
                             input string name, input int exp_cycles,
                             input logic exp_err, input logic [31:0] exp_data,
                             input logic [7:0] exp_cnt);
    int n = 0;
    p_data_in[31:0] = 32'h12345678;
    cpu_addr = 28'h0000000; cpu_read_n = 2'b10;
    tick();
    idle_cpu(); p_ready = rdy;
    while (p_read_n[1:0] === 2'b10 && n < 40) begin
      n++;
      if (n == late_ready) p_ready = 3'b001;
      tick();
    end
    p_ready = '0;
    checks++; if (n !== exp_cycles) begin errors++; $display("FAIL %s_cycles: got %0d exp %0d", name, n, exp_cycles); end
    checks++; if (cpu_data_ready !== 1'b1 || cpu_data_in !== exp_data) begin errors++; $display("FAIL %s_resp: got rdy=%b data=%h exp 1 %h", name, cpu_data_ready, cpu_data_in, exp_data); end
    checks++; if (bus_error !== exp_err || err_count !== exp_cnt) begin errors++; $display("FAIL %s_err: got err=%b cnt=%0d exp %b %0d", name, bus_error, err_count, exp_err, exp_cnt); end
    tick();
    checks++; if (bus_error !== 1'b0 || cpu_data_ready !== 1'b0) begin errors++; $display("FAIL %s_pulse: got err=%b rdy=%b exp 0 0", name, bus_error, cpu_data_ready); end
  endtask

  task automatic test_timeout();
    run_timeout(3'b000, 0, "to", 15, 1'b1, 32'd0, 8'd1);
    run_timeout(3'b110, 0, "other_rdy", 15, 1'b1, 32'd0, 8'd2);
    run_timeout(3'b000, 15, "coincide", 15, 1'b0, 32'h12345678, 8'd2);
  endtask

  task automatic test_unmapped();
    cpu_addr = 28'h00000C0; cpu_write_n = 2'b10; cpu_data_out = 32'h77;
    tick();
    idle_cpu();
    checks++; if (p_write_n !== 6'h3F || p_read_n !== 6'h3F) begin errors++; $display("FAIL unm_strobe: got pw=%b pr=%b exp all 1", p_write_n, p_read_n); end
    checks++; if (cpu_data_ready !== 1'b1 || bus_error !== 1'b1 || err_count !== 8'd3) begin errors++; $display("FAIL unm_resp: got rdy=%b err=%b cnt=%0d exp 1 1 3", cpu_data_ready, bus_error, err_count); end
    tick();
    for (int i = 1; i < 300; i++) begin
      cpu_read_n = 2'b00;
      tick();
      idle_cpu();
      tick();
    end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL unm_saturate: got %0d exp 255", err_count); end
  endtask

  task automatic test_reset_mid_active();
    int stray = 0;
    cpu_addr = 28'h0000040; cpu_read_n = 2'b01;
    tick();
    idle_cpu();
    tick();
    checks++; if (p_read_n !== 6'b11_01_11) begin errors++; $display("FAIL rst_pre: got %b exp 110111", p_read_n); end
    rstn = 1'b0;
    #1;
    checks++; if (p_read_n !== 6'h3F || err_count !== 8'd0) begin errors++; $display("FAIL rst_async: got pr=%b cnt=%0d exp 111111 0", p_read_n, err_count); end
    tick();
    rstn = 1'b1;
    p_ready = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_data_ready !== 1'b0) stray++;
    end
    p_ready = '0;
    checks++; if (stray !== 0) begin errors++; $display("FAIL rst_no_rdy: got %0d pulses exp 0", stray); end
    p_data_in[64 +: 32] = 32'hA5A5_0001;
    cpu_addr = 28'h0000080; cpu_read_n = 2'b10;
    tick();
    idle_cpu(); p_ready = 3'b100;
    tick();
    p_ready = '0;
    checks++; if (cpu_data_ready !== 1'b1 || cpu_data_in !== 32'hA5A50001 || bus_error !== 1'b0) begin errors++; $display("FAIL rst_after: got rdy=%b data=%h err=%b exp 1 a5a50001 0", cpu_data_ready, cpu_data_in, bus_error); end
    tick();
  endtask

  initial begin
    test_reset();
    test_read_min();
    test_write_byte();
    test_both_strobes();
    test_back_to_back();
    test_timeout();
    test_unmapped();
    test_reset_mid_active();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
